// File: rtl/dmem_ext_if.sv
// dmem_ext_if: load/store bus between the MEM stage and dmem_ext
//   master drives CS, DM_W, DM_R, DM_SIZE, DM_SIGNED, addr, wdata
//   slave  drives rdata, rvalid, err
interface dmem_ext_if #(parameter int ADDR_W = 32);
    logic              CS;
    logic              DM_W;
    logic              DM_R;
    logic [1:0]        DM_SIZE;
    logic              DM_SIGNED;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              err;
    modport master (output CS, DM_W, DM_R, DM_SIZE, DM_SIGNED, addr, wdata,
                    input  rdata, rvalid, err);
    modport slave  (input  CS, DM_W, DM_R, DM_SIZE, DM_SIGNED, addr, wdata,
                    output rdata, rvalid, err);
endinterface

// File: rtl/dmem_ext.sv
// dmem_ext: byte-addressable data RAM with lane stores, extended loads and fault flag
//   clk, rst : clock, synchronous active-high reset
//   bus      : dmem_ext_if slave (request in, registered rdata/rvalid/err out)
module dmem_ext #(
    parameter int DEPTH     = 2048,
    parameter int ADDR_W    = 32,
    parameter bit BYTE_ADDR = 1
) (
    input logic        clk,
    input logic        rst,
    dmem_ext_if.slave  bus
);
    localparam int AW = DEPTH > 2 ? $clog2(DEPTH) : 1;
    localparam int IW = ADDR_W > 32 ? ADDR_W : 32;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [IW-1:0]     idx_w;
    logic [AW-1:0]     ram_idx;
    logic [1:0]        off, sz;
    logic              req, fault, wr, rd;
    logic [3:0]        be;
    logic [31:0]       wd;
    logic [31:0]       ram_q, sh;
    logic [1:0]        r_off, r_sz;
    logic              r_sgn, r_zero;

    always_comb begin
        idx     = BYTE_ADDR ? (bus.addr >> 2) : bus.addr;
        idx_w   = IW'(idx);
        ram_idx = idx[AW-1:0];
        off     = BYTE_ADDR ? bus.addr[1:0] : 2'b00;
        sz      = BYTE_ADDR ? bus.DM_SIZE : 2'b10;
        // full-width index compare so out-of-range addresses never alias
        fault   = (idx_w >= IW'(DEPTH)) || (sz == 2'b11) ||
                  (sz == 2'b01 && off[0]) || (sz == 2'b10 && off != 2'b00);
        req     = bus.CS && (bus.DM_W || bus.DM_R);
        wr      = !rst && bus.CS && bus.DM_W && !fault;
        rd      = bus.CS && bus.DM_R;
        be      = sz == 2'b00 ? 4'b0001 << off : sz == 2'b01 ? 4'b0011 << off : 4'b1111;
        wd      = sz == 2'b00 ? {4{bus.wdata[7:0]}} : sz == 2'b01 ? {2{bus.wdata[15:0]}} : bus.wdata;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (wr && be[i]) mem[ram_idx][8*i +: 8] <= wd[8*i +: 8];
    end

    // read-first: ram_q captures the word before any same-edge store lands
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
            r_zero     <= 1'b1;
        end else begin
            bus.rvalid <= rd;
            bus.err    <= req && fault;
            if (rd) begin
                r_zero <= fault;
                r_off  <= off;
                r_sz   <= sz;
                r_sgn  <= bus.DM_SIGNED;
                if (!fault) ram_q <= mem[ram_idx];
            end
        end
    end

    // lane select and extension sit after the RAM register
    always_comb begin
        sh        = ram_q >> {r_off, 3'b000};
        bus.rdata = r_zero ? 32'h0 :
                    r_sz == 2'b00 ? {{24{r_sgn & sh[7]}}, sh[7:0]} :
                    r_sz == 2'b01 ? {{16{r_sgn & sh[15]}}, sh[15:0]} : ram_q;
    end
endmodule

// File: tb/tb_dmem_ext.sv
// tb_dmem_ext: directed-vector bench for dmem_ext in byte and legacy word modes
module tb_dmem_ext;
    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dmem_ext_if #(.ADDR_W(32)) b ();
    dmem_ext_if #(.ADDR_W(32)) l ();

    dmem_ext #(.DEPTH(DEPTH), .ADDR_W(32), .BYTE_ADDR(1)) dut_b (.clk(clk), .rst(rst), .bus(b));
    dmem_ext #(.DEPTH(16),    .ADDR_W(32), .BYTE_ADDR(0)) dut_l (.clk(clk), .rst(rst), .bus(l));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic set(input bit u, input bit cs, input bit w, input bit r,
                       input logic [1:0] sz, input bit sg, input logic [31:0] a, input logic [31:0] d);
        if (u) begin
            l.CS = cs; l.DM_W = w; l.DM_R = r; l.DM_SIZE = sz; l.DM_SIGNED = sg; l.addr = a; l.wdata = d;
        end else begin
            b.CS = cs; b.DM_W = w; b.DM_R = r; b.DM_SIZE = sz; b.DM_SIGNED = sg; b.addr = a; b.wdata = d;
        end
    endtask

    // apply one request for one edge, then return the bus to idle
    task automatic op(input bit u, input bit cs, input bit w, input bit r,
                      input logic [1:0] sz, input bit sg, input logic [31:0] a, input logic [31:0] d);
        set(u, cs, w, r, sz, sg, a, d);
        @(posedge clk);
        #1;
        set(u, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        op(1'b0, 1'b1, 1'b1, 1'b0, sz, 1'b0, a, d);
    endtask

    task automatic rd(input logic [1:0] sz, input bit sg, input logic [31:0] a);
        op(1'b0, 1'b1, 1'b0, 1'b1, sz, sg, a, 32'h0);
    endtask

    initial begin
        set(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        set(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        wr(2'b10, 32'h10, 32'h0BADF00D);
        wr(2'b10, 32'h00, 32'h55AA55AA);

        rst = 1'b1;
        set(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", b.rdata, 32'h0);
        chk("rst_rvalid", {31'b0, b.rvalid}, 32'h0);
        chk("rst_err", {31'b0, b.err}, 32'h0);
        rst = 1'b0;
        set(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);

        rd(2'b10, 1'b0, 32'h10);
        chk("rst_nowrite", b.rdata, 32'h0BADF00D);

        wr(2'b10, 32'h40, 32'h12345678);
        chk("wr_rvalid", {31'b0, b.rvalid}, 32'h0);
        rd(2'b10, 1'b0, 32'h40);
        chk("word_rvalid", {31'b0, b.rvalid}, 32'h1);
        chk("word_rdata", b.rdata, 32'h12345678);
        @(posedge clk);
        #1;
        chk("idle_rvalid", {31'b0, b.rvalid}, 32'h0);
        chk("idle_hold", b.rdata, 32'h12345678);

        wr(2'b00, 32'h41, 32'h000000AA);
        wr(2'b01, 32'h42, 32'h000080FF);
        rd(2'b10, 1'b0, 32'h40);
        chk("lanes_word", b.rdata, 32'h80FFAA78);
        rd(2'b00, 1'b1, 32'h41);
        chk("byte_s", b.rdata, 32'hFFFFFFAA);
        rd(2'b00, 1'b0, 32'h41);
        chk("byte_u", b.rdata, 32'h000000AA);
        rd(2'b00, 1'b0, 32'h40);
        chk("byte0_u", b.rdata, 32'h00000078);
        rd(2'b01, 1'b1, 32'h42);
        chk("half_s", b.rdata, 32'hFFFF80FF);
        rd(2'b01, 1'b0, 32'h42);
        chk("half_u", b.rdata, 32'h000080FF);
        rd(2'b10, 1'b1, 32'h40);
        chk("word_sgn_ign", b.rdata, 32'h80FFAA78);

        rd(2'b10, 1'b0, 32'h42);
        chk("mis_word_err", {31'b0, b.err}, 32'h1);
        chk("mis_word_rvalid", {31'b0, b.rvalid}, 32'h1);
        chk("mis_word_rdata", b.rdata, 32'h0);
        wr(2'b01, 32'h43, 32'h00001234);
        chk("mis_half_err", {31'b0, b.err}, 32'h1);
        chk("mis_half_rvalid", {31'b0, b.rvalid}, 32'h0);
        rd(2'b11, 1'b0, 32'h40);
        chk("rsv_err", {31'b0, b.err}, 32'h1);
        chk("rsv_rdata", b.rdata, 32'h0);
        rd(2'b10, 1'b0, 32'h40);
        chk("mis_half_nowr", b.rdata, 32'h80FFAA78);
        chk("ok_err", {31'b0, b.err}, 32'h0);
        wr(2'b10, 4 * DEPTH, 32'hFFFFFFFF);
        chk("oob_err", {31'b0, b.err}, 32'h1);
        rd(2'b10, 1'b0, 32'h0);
        chk("oob_nowrap", b.rdata, 32'h55AA55AA);

        wr(2'b10, 32'h80, 32'h11111111);
        op(1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h80, 32'h22222222);
        chk("rf_old", b.rdata, 32'h11111111);
        chk("rf_rvalid", {31'b0, b.rvalid}, 32'h1);
        rd(2'b10, 1'b0, 32'h80);
        chk("rf_new", b.rdata, 32'h22222222);

        op(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'd5, 32'hCAFEF00D);
        op(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'd5, 32'h0);
        chk("leg_word", l.rdata, 32'hCAFEF00D);
        op(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'd16, 32'h0);
        chk("leg_oob_err", {31'b0, l.err}, 32'h1);
        chk("leg_oob_rdata", l.rdata, 32'h0);
        op(1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'd5, 32'h0);
        chk("cs0_rvalid", {31'b0, l.rvalid}, 32'h0);
        chk("cs0_err", {31'b0, l.err}, 32'h0);
        op(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'd5, 32'h0);
        chk("cs0_nowrite", l.rdata, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_ext.md
Name: dmem_ext

Overview:
- Parametrised next-generation data memory for the CPU datapath; replaces the word-only, combinational-read data RAM.
- Adds a byte-address mode, byte/halfword/word stores with byte-lane enables, and sign- or zero-extended loads.
- Read is synchronous (registered) and qualified by a valid strobe; misaligned and out-of-range accesses raise a fault flag.
- Sits between the MEM stage and the load/store unit.

Parameters:
- DEPTH, 2048: number of 32-bit words; any value ≥ 2, not necessarily a power of 2.
- ADDR_W, 32: width of the addr port.
- BYTE_ADDR, 1:
  - 1: addr is a byte address, word index = addr[ADDR_W-1:2].
  - 0: addr is a word index (legacy mode), DM_SIZE ignored and all accesses treated as word.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- CS  input  1  chip select; no access without it.
- DM_W  input  1  write request.
- DM_R  input  1  read request.
- DM_SIZE  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- DM_SIGNED  input  1  loads: 1 sign-extend, 0 zero-extend.
- addr  input  ADDR_W  access address.
- wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- rdata  output  32  load result, registered.
- rvalid  output  1  one-cycle pulse; rdata holds the result of the read sampled on the previous edge.
- err  output  1  one-cycle pulse; the access sampled on the previous edge faulted.

Behaviour:
- Reset:
  - On a rising edge with rst=1: rdata=0, rvalid=0, err=0.
  - Any request in the same cycle is discarded (no write).
  - RAM contents are not cleared.
- Request sampling: a request exists at an edge when CS=1 and (DM_W or DM_R). CS=0 means no request, whatever DM_W and DM_R are.
- Index and offset:
  - BYTE_ADDR=1: idx = addr>>2, off = addr[1:0].
  - BYTE_ADDR=0: idx = addr, off = 0, size forced to word.
- Fault conditions (err pulses the cycle after the request):
  - idx ≥ DEPTH (compare the full-width index, no truncation).
  - DM_SIZE=11.
  - Halfword with off[0]=1.
  - Word with off≠0.
- Faulted access:
  - No RAM write.
  - If DM_R was set, rvalid=1 and rdata=0.
- Store, little-endian lane enables:
  - Byte: writes lane off with wdata[7:0].
  - Halfword: writes lanes off and off+1 with wdata[15:0].
  - Word: writes all four lanes with wdata.
  - Unwritten lanes keep their contents.
  - Write commits at the sampling edge.
- Load:
  - Selects lane(s) at off and extends to 32 bits per DM_SIGNED.
  - Word loads ignore DM_SIGNED.
  - Result is registered: rdata and rvalid=1 on the edge after the request (latency 1).
  - Cycles without a read: rvalid=0, rdata holds its last value.
- Simultaneous DM_W and DM_R, same edge:
  - Both are performed.
  - The read returns pre-write data (read-first).
  - One fault check covers both.
- Back-to-back: a read sampled on the edge after a write to the same word returns the new data. No forwarding logic is needed beyond the committed RAM.
- Read-data mux: implemented once from the registered RAM word, off, size and signed fields, so only the RAM read itself sits before the output register.
- Uninitialised words read as X in simulation. The bench writes before reading.

Test Plan:
- Reset/hold:
  - rst=1 for 2 cycles with CS=1, DM_W=1, addr=0x10, wdata=0xDEADBEEF → rdata=0, rvalid=0, err=0.
  - A later word read of 0x10 does not return 0xDEADBEEF.
- Word store/load latency:
  - Write 0x12345678 to 0x40, then read 0x40 on the next cycle → rvalid=1 exactly one cycle after the read, rdata=0x12345678.
  - With no further reads: rvalid=0 and rdata stays 0x12345678.
- Byte/half lanes:
  - Write word 0x12345678 to 0x40, store byte 0xAA at 0x41, store half 0x80FF at 0x42.
  - Word read → 0x80FFAA78.
  - Signed byte read of 0x41 → 0xFFFFFFAA; unsigned → 0x000000AA.
  - Signed half read of 0x42 → 0xFFFF80FF.
- Faults:
  - Word read at 0x42 → err=1 and rvalid=1, rdata=0.
  - Half write at 0x43 → err=1, memory unchanged.
  - Word write at byte address 4*DEPTH → err=1, and word 0 is unchanged (no wrap-around).
- Read-first collision: word at 0x80 holds 0x11111111; DM_W=DM_R=1 at 0x80 with wdata=0x22222222 → rdata=0x11111111; the next read returns 0x22222222.
- Legacy mode, BYTE_ADDR=0, DEPTH=16:
  - Write 0xCAFEF00D at addr 5 with DM_SIZE=00 → a read of addr 5 returns 0xCAFEF00D (size ignored).
  - Addr 16 → err=1.
  - CS=0 with DM_W=1 → no write, no rvalid, no err.
